// File: rtl/avr_fetch_sequencer.sv
// AVR instruction-sequencing controller: fetches and decodes program words, runs control
// flow (jmp/call/rjmp/ret) with its own PC/SP, and hands ALU-class work to the execute unit.
module avr_fetch_sequencer #(
  parameter int unsigned PC_W    = 16,
  parameter logic [15:0] SP_INIT = 16'h08FF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  output logic [PC_W-1:0] pm_addr,
  output logic            pm_rd,
  input  logic [15:0]     pm_rdata,
  output logic [15:0]     dec_word,
  input  logic [7:0]      dec_opcode,
  output logic            exec_start,
  output logic [15:0]     exec_word,
  input  logic            exec_done,
  output logic [15:0]     dm_addr,
  output logic [7:0]      dm_wdata,
  output logic            dm_we,
  output logic            dm_rd,
  input  logic [7:0]      dm_rdata,
  output logic [PC_W-1:0] pc_out,
  output logic [15:0]     sp_out,
  output logic            stopped,
  output logic            halted,
  output logic [PC_W-1:0] fault_pc
);

  localparam int unsigned WORD_W = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned OP_W   = 8;

  localparam logic [OP_W-1:0] OP_LDI  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_JMP  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_CALL = OP_W'(3);
  localparam logic [OP_W-1:0] OP_OUT  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_RET  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_CLI  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_RJMP = OP_W'(7);
  localparam logic [OP_W-1:0] OP_EOR  = OP_W'(8);

  typedef enum logic [3:0] {
    S_F1   = 4'd0,
    S_L1   = 4'd1,
    S_D    = 4'd2,
    S_F2   = 4'd3,
    S_L2   = 4'd4,
    S_P1   = 4'd5,
    S_P2   = 4'd6,
    S_R1   = 4'd7,
    S_R2   = 4'd8,
    S_R3   = 4'd9,
    S_E    = 4'd10,
    S_HALT = 4'd11
  } state_e;

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [WORD_W-1:0]   sp_q, sp_d;
  logic [WORD_W-1:0]   ir_q, ir_d;
  logic [WORD_W-1:0]   k_q, k_d;
  logic [BYTE_W-1:0]   hi_q, hi_d;
  logic                is_call_q, is_call_d;
  logic                started_q, started_d;
  logic [PC_W-1:0]     fault_pc_q, fault_pc_d;

  logic [WORD_W-1:0]   rel_c;
  logic [WORD_W-1:0]   pc_wide_c;

  // rjmp displacement is a signed 12-bit word offset
  assign rel_c     = {{4{ir_q[11]}}, ir_q[11:0]};
  assign pc_wide_c = WORD_W'(pc_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_F1;
      pc_q       <= '0;
      sp_q       <= SP_INIT;
      ir_q       <= '0;
      k_q        <= '0;
      hi_q       <= '0;
      is_call_q  <= 1'b0;
      started_q  <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      sp_q       <= sp_d;
      ir_q       <= ir_d;
      k_q        <= k_d;
      hi_q       <= hi_d;
      is_call_q  <= is_call_d;
      started_q  <= started_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    sp_d       = sp_q;
    ir_d       = ir_q;
    k_d        = k_q;
    hi_d       = hi_q;
    is_call_d  = is_call_q;
    started_d  = started_q;
    fault_pc_d = fault_pc_q;

    unique case (state_q)
      S_F1: begin
        if (run) state_d = S_L1;
      end
      S_L1: begin
        ir_d    = pm_rdata;
        pc_d    = pc_q + PC_W'(1);
        state_d = S_D;
      end
      S_D: begin
        unique case (dec_opcode)
          OP_LDI, OP_OUT, OP_CLI, OP_EOR: begin
            started_d = 1'b0;
            state_d   = S_E;
          end
          OP_RJMP: begin
            pc_d    = pc_q + PC_W'(rel_c);
            state_d = S_F1;
          end
          OP_JMP, OP_CALL: begin
            is_call_d = (dec_opcode == OP_CALL);
            state_d   = S_F2;
          end
          OP_RET: begin
            state_d = S_R1;
          end
          default: begin
            fault_pc_d = pc_q - PC_W'(1);
            state_d    = S_HALT;
          end
        endcase
      end
      S_F2: begin
        state_d = S_L2;
      end
      S_L2: begin
        k_d = pm_rdata;
        if (is_call_q) begin
          pc_d    = pc_q + PC_W'(1);
          state_d = S_P1;
        end else begin
          pc_d    = PC_W'(pm_rdata);
          state_d = S_F1;
        end
      end
      S_P1: begin
        sp_d    = sp_q - WORD_W'(1);
        state_d = S_P2;
      end
      S_P2: begin
        sp_d    = sp_q - WORD_W'(1);
        pc_d    = PC_W'(k_q);
        state_d = S_F1;
      end
      S_R1: begin
        sp_d    = sp_q + WORD_W'(1);
        state_d = S_R2;
      end
      S_R2: begin
        hi_d    = dm_rdata;
        sp_d    = sp_q + WORD_W'(1);
        state_d = S_R3;
      end
      S_R3: begin
        pc_d    = PC_W'({hi_q, dm_rdata});
        state_d = S_F1;
      end
      S_E: begin
        started_d = 1'b1;
        if (exec_done) state_d = S_F1;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_F1;
      end
    endcase
  end

  // Strobes decode straight from the state register; reset suppresses them immediately
  always_comb begin
    pm_rd      = 1'b0;
    dm_rd      = 1'b0;
    dm_we      = 1'b0;
    dm_addr    = sp_q;
    dm_wdata   = '0;
    exec_start = 1'b0;
    stopped    = 1'b0;
    halted     = 1'b0;

    unique case (state_q)
      S_F1: begin
        pm_rd   = run;
        stopped = ~run;
      end
      S_F2: pm_rd = 1'b1;
      S_P1: begin
        dm_we    = 1'b1;
        dm_wdata = pc_wide_c[7:0];
      end
      S_P2: begin
        dm_we    = 1'b1;
        dm_wdata = pc_wide_c[15:8];
      end
      S_R1, S_R2: begin
        dm_rd   = 1'b1;
        dm_addr = sp_q + WORD_W'(1);
      end
      S_E:    exec_start = ~started_q;
      S_HALT: halted = 1'b1;
      default: ;
    endcase

    if (reset) begin
      pm_rd      = 1'b0;
      dm_rd      = 1'b0;
      dm_we      = 1'b0;
      exec_start = 1'b0;
      stopped    = 1'b0;
      halted     = 1'b0;
    end
  end

  assign pm_addr   = pc_q;
  assign dec_word  = ir_q;
  assign exec_word = ir_q;
  assign pc_out    = pc_q;
  assign sp_out    = sp_q;
  assign fault_pc  = fault_pc_q;

endmodule

// File: tb/tb_avr_fetch_sequencer.sv
// Bench for avr_fetch_sequencer: random programs run against an instruction-level model
// of PC/SP/stack effects and per-instruction cycle counts, plus directed halt/reset cases.
module tb_avr_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset, run;
  logic [15:0] pm_addr, pm_rdata, dec_word, exec_word, dm_addr, pc_out, sp_out, fault_pc;
  logic        pm_rd, exec_start, exec_done, dm_we, dm_rd, stopped, halted;
  logic [7:0]  dec_opcode, dm_wdata, dm_rdata;

  avr_fetch_sequencer #(.PC_W(16), .SP_INIT(16'h08FF)) dut (
    .clk(clk), .reset(reset), .run(run),
    .pm_addr(pm_addr), .pm_rd(pm_rd), .pm_rdata(pm_rdata),
    .dec_word(dec_word), .dec_opcode(dec_opcode),
    .exec_start(exec_start), .exec_word(exec_word), .exec_done(exec_done),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_rd(dm_rd), .dm_rdata(dm_rdata),
    .pc_out(pc_out), .sp_out(sp_out), .stopped(stopped), .halted(halted), .fault_pc(fault_pc)
  );

  always #5 clk = ~clk;

  logic [15:0] pm     [0:65535];
  logic [7:0]  dm_mem [0:65535];
  logic [7:0]  m_dm   [0:65535];
  logic [15:0] m_pc, m_sp;

  int n_checks = 0, n_pass = 0;
  logic [15:0] pm_pend; logic pm_pend_v = 1'b0;
  logic [7:0]  dm_pend; logic dm_pend_v = 1'b0;
  logic busy = 1'b0; int left = 0; int cur_d = 0;
  int n_st, n_we, n_rd, n_viol;
  logic [15:0] st_word;

  function automatic logic [7:0] tb_decode(input logic [15:0] w);
    if (w[15:12] == 4'hE)                   return 8'd1;
    if ((w & 16'hFE0E) == 16'h940C)         return 8'd2;
    if ((w & 16'hFE0E) == 16'h940E)         return 8'd3;
    if (w[15:11] == 5'b10111)               return 8'd4;
    if (w == 16'h9508)                      return 8'd5;
    if (w == 16'h94F8)                      return 8'd6;
    if (w[15:12] == 4'hC)                   return 8'd7;
    if (w[15:10] == 6'b001001)              return 8'd8;
    return 8'd0;
  endfunction

  assign dec_opcode = tb_decode(dec_word);

  function automatic logic [15:0] gen_word();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 15))
      0, 1, 2, 14, 15: return 16'hE000 | (r & 16'h0FFF);
      3:               return 16'hB800 | (r & 16'h07FF);
      4:               return 16'h2400 | (r & 16'h03FF);
      5:               return 16'h94F8;
      6, 7:            return 16'hC000 | (r & 16'h0FFF);
      8, 9:            return 16'h940C | (r & 16'h01F1);
      10, 11:          return 16'h940E | (r & 16'h01F1);
      default:         return 16'h9508;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock: memories answer last cycle's reads, drive inputs, sample strobes, drive exec_done
  task automatic step(input logic r, input logic rs);
    @(negedge clk);
    if (pm_pend_v) pm_rdata = pm_pend;
    if (dm_pend_v) dm_rdata = dm_pend;
    pm_pend_v = 1'b0; dm_pend_v = 1'b0;
    run = r; reset = rs;
    #1;
    if (pm_rd) begin pm_pend = pm[pm_addr]; pm_pend_v = 1'b1; end
    if (dm_rd) begin dm_pend = dm_mem[dm_addr]; dm_pend_v = 1'b1; n_rd++; end
    if (dm_we) begin dm_mem[dm_addr] = dm_wdata; n_we++; end
    if ((32'(pm_rd) + 32'(dm_rd) + 32'(dm_we)) > 32'd1) n_viol++;
    if (exec_start) begin n_st++; st_word = exec_word; busy = 1'b1; left = cur_d; end
    else if (busy) left--;
    exec_done = busy && (left == 0);
    if (exec_done) busy = 1'b0;
    if (rs) begin busy = 1'b0; exec_done = 1'b0; end
  endtask

  task automatic do_reset();
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    m_pc = 16'h0000; m_sp = 16'h08FF;
  endtask

  // Run one instruction starting in F1, comparing against the instruction-level model
  task automatic run_instr();
    logic [15:0] w, ra, nx, wa0, wa1, rel;
    logic [7:0]  op, hi, lo;
    int lat, exp_st, exp_we, exp_rd, stalls;
    logic is_call;
    stalls = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
    for (int s = 0; s < stalls; s++) begin
      step(1'b0, 1'b0);
      chk("stall_stopped", 32'(stopped), 32'd1);
      chk("stall_pm_rd", 32'(pm_rd), 32'd0);
    end
    cur_d = $urandom_range(0, 3);
    step(1'b1, 1'b0);
    chk("fetch_rd", 32'(pm_rd), 32'd1);
    chk("fetch_addr", 32'(pm_addr), 32'(m_pc));
    chk("pc", 32'(pc_out), 32'(m_pc));
    chk("sp", 32'(sp_out), 32'(m_sp));
    chk("run_flags", {30'd0, stopped, halted}, 32'd0);
    n_st = 0; n_we = 0; n_rd = 0; n_viol = 0;

    w = pm[m_pc]; op = tb_decode(w); nx = m_pc + 16'd1;
    exp_st = 0; exp_we = 0; exp_rd = 0; is_call = 1'b0; wa0 = '0; wa1 = '0; ra = '0;
    case (op)
      8'd1, 8'd4, 8'd6, 8'd8: begin m_pc = nx; lat = 4 + cur_d; exp_st = 1; end
      8'd7: begin rel = {{4{w[11]}}, w[11:0]}; m_pc = nx + rel; lat = 3; end
      8'd2: begin m_pc = pm[nx]; lat = 5; end
      8'd3: begin
        ra = m_pc + 16'd2; wa0 = m_sp; wa1 = m_sp - 16'd1;
        m_dm[wa0] = ra[7:0]; m_dm[wa1] = ra[15:8];
        m_sp = m_sp - 16'd2; m_pc = pm[nx]; lat = 7; exp_we = 2; is_call = 1'b1;
      end
      8'd5: begin
        hi = m_dm[16'(m_sp + 16'd1)]; lo = m_dm[16'(m_sp + 16'd2)];
        m_sp = m_sp + 16'd2; m_pc = {hi, lo}; lat = 6; exp_rd = 2;
      end
      default: lat = 3;
    endcase

    for (int i = 1; i < lat; i++) step(1'($urandom_range(0, 1)), 1'b0);
    chk("exec_starts", 32'(n_st), 32'(exp_st));
    if (exp_st != 0) chk("exec_word", 32'(st_word), 32'(w));
    chk("dm_writes", 32'(n_we), 32'(exp_we));
    chk("dm_reads", 32'(n_rd), 32'(exp_rd));
    chk("strobe_excl", 32'(n_viol), 32'd0);
    if (is_call) begin
      chk("push_lo", 32'(dm_mem[wa0]), 32'(ra[7:0]));
      chk("push_hi", 32'(dm_mem[wa1]), 32'(ra[15:8]));
    end
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; exec_done = 1'b0; pm_rdata = '0; dm_rdata = '0;
    for (int a = 0; a < 65536; a++) begin
      pm[a] = gen_word();
      dm_mem[a] = 8'($urandom);
      m_dm[a] = dm_mem[a];
    end
    pm[16'h0000] = 16'hE50A;
    pm[16'h0001] = 16'h940C; pm[16'h0002] = 16'h0100;
    pm[16'h0100] = 16'h940E; pm[16'h0101] = 16'h0040;
    pm[16'h0040] = 16'h9508;
    pm[16'h0102] = 16'hC001;

    step(1'b0, 1'b1);
    chk("rst_strobes", {27'd0, pm_rd, dm_rd, dm_we, exec_start, stopped}, 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    do_reset();
    step(1'b0, 1'b0);
    chk("rst_pc", 32'(pc_out), 32'd0);
    chk("rst_sp", 32'(sp_out), 32'h08FF);
    chk("rst_fault_pc", 32'(fault_pc), 32'd0);
    chk("rst_ir", 32'(dec_word), 32'd0);
    chk("idle_stopped", 32'(stopped), 32'd1);
    chk("idle_pm_rd", 32'(pm_rd), 32'd0);

    for (int n = 0; n < 400; n++) run_instr();
    step(1'b1, 1'b0);
    chk("final_pc", 32'(pc_out), 32'(m_pc));
    chk("final_sp", 32'(sp_out), 32'(m_sp));

    // Error trap: rjmp +2 from 0 lands on an undecodable word at 3
    do_reset();
    pm[16'h0000] = 16'hC002; pm[16'h0003] = 16'h0000;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
    n_viol = 0; n_we = 0; n_rd = 0; n_st = 0;
    step(1'b1, 1'b0);
    chk("halted", 32'(halted), 32'd1);
    chk("fault_pc", 32'(fault_pc), 32'd3);
    for (int i = 0; i < 4; i++) begin
      step(1'($urandom_range(0, 1)), 1'b0);
      chk("halt_pm_rd", 32'(pm_rd), 32'd0);
      chk("halt_pc", 32'(pc_out), 32'd4);
    end
    chk("halt_dm", 32'(n_we + n_rd + n_st), 32'd0);

    // Reset during the second push of a call
    do_reset();
    pm[16'h0000] = 16'h940E; pm[16'h0001] = 16'h0040;
    dm_mem[16'h08FE] = 8'hA5;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("p2_rst_we", 32'(dm_we), 32'd0);
    step(1'b1, 1'b0);
    chk("p2_rst_pc", 32'(pc_out), 32'd0);
    chk("p2_rst_sp", 32'(sp_out), 32'h08FF);
    chk("p2_rst_fetch", {15'd0, pm_rd, pm_addr}, 32'h0001_0000);
    chk("p2_rst_we2", 32'(dm_we), 32'd0);
    chk("p2_push_lo", 32'(dm_mem[16'h08FF]), 32'h02);
    chk("p2_no_hi", 32'(dm_mem[16'h08FE]), 32'hA5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
